// File: rtl/golf_pkg.sv
// Shared types and constants for the golf ball motion controller:
// FSM state encoding, start/limit positions (11.5 fixed point), the Q8
// sine quarter-wave table and the per-axis position step helper.
package golf_pkg;

    typedef enum logic [1:0] {
        ST_AIM   = 2'd0,
        ST_LATCH = 2'd1,
        ST_ROLL  = 2'd2
    } state_t;

    localparam logic [15:0] START_X = 16'h1400;   // 160 px
    localparam logic [15:0] START_Y = 16'h2D00;   // 360 px
    localparam logic [16:0] X_MAX   = 17'd40928;  // 1279 px
    localparam logic [16:0] Y_MAX   = 17'd23008;  // 719 px

    typedef struct packed {
        logic [15:0] pos;
        logic        hit;
    } axis_step_t;

    // round(256 * sin(deg)) for deg = 0..90
    function automatic logic [8:0] sin_q8(input logic [6:0] deg);
        logic [8:0] v;
        v = '0;
        case (deg)
            7'd0:  v = 9'd0;   7'd1:  v = 9'd4;   7'd2:  v = 9'd9;   7'd3:  v = 9'd13;  7'd4:  v = 9'd18;
            7'd5:  v = 9'd22;  7'd6:  v = 9'd27;  7'd7:  v = 9'd31;  7'd8:  v = 9'd36;  7'd9:  v = 9'd40;
            7'd10: v = 9'd44;  7'd11: v = 9'd49;  7'd12: v = 9'd53;  7'd13: v = 9'd58;  7'd14: v = 9'd62;
            7'd15: v = 9'd66;  7'd16: v = 9'd71;  7'd17: v = 9'd75;  7'd18: v = 9'd79;  7'd19: v = 9'd83;
            7'd20: v = 9'd88;  7'd21: v = 9'd92;  7'd22: v = 9'd96;  7'd23: v = 9'd100; 7'd24: v = 9'd104;
            7'd25: v = 9'd108; 7'd26: v = 9'd112; 7'd27: v = 9'd116; 7'd28: v = 9'd120; 7'd29: v = 9'd124;
            7'd30: v = 9'd128; 7'd31: v = 9'd132; 7'd32: v = 9'd136; 7'd33: v = 9'd139; 7'd34: v = 9'd143;
            7'd35: v = 9'd147; 7'd36: v = 9'd150; 7'd37: v = 9'd154; 7'd38: v = 9'd158; 7'd39: v = 9'd161;
            7'd40: v = 9'd165; 7'd41: v = 9'd168; 7'd42: v = 9'd171; 7'd43: v = 9'd175; 7'd44: v = 9'd178;
            7'd45: v = 9'd181; 7'd46: v = 9'd184; 7'd47: v = 9'd187; 7'd48: v = 9'd190; 7'd49: v = 9'd193;
            7'd50: v = 9'd196; 7'd51: v = 9'd199; 7'd52: v = 9'd202; 7'd53: v = 9'd204; 7'd54: v = 9'd207;
            7'd55: v = 9'd210; 7'd56: v = 9'd212; 7'd57: v = 9'd215; 7'd58: v = 9'd217; 7'd59: v = 9'd219;
            7'd60: v = 9'd222; 7'd61: v = 9'd224; 7'd62: v = 9'd226; 7'd63: v = 9'd228; 7'd64: v = 9'd230;
            7'd65: v = 9'd232; 7'd66: v = 9'd234; 7'd67: v = 9'd236; 7'd68: v = 9'd237; 7'd69: v = 9'd239;
            7'd70: v = 9'd241; 7'd71: v = 9'd242; 7'd72: v = 9'd243; 7'd73: v = 9'd245; 7'd74: v = 9'd246;
            7'd75: v = 9'd247; 7'd76: v = 9'd248; 7'd77: v = 9'd249; 7'd78: v = 9'd250; 7'd79: v = 9'd251;
            7'd80: v = 9'd252; 7'd81: v = 9'd253; 7'd82: v = 9'd254; 7'd83: v = 9'd254; 7'd84: v = 9'd255;
            7'd85: v = 9'd255; 7'd86: v = 9'd255; 7'd87: v = 9'd256; 7'd88: v = 9'd256; 7'd89: v = 9'd256;
            7'd90: v = 9'd256;
            default: v = '0;
        endcase
        return v;
    endfunction

    // Move one axis by delta in the flagged direction using a 17-bit signed
    // intermediate; clamp to [0, max_pos] and report whether it clamped.
    function automatic axis_step_t axis_step(input logic [15:0] pos, input logic [12:0] delta,
                                             input logic neg, input logic [16:0] max_pos);
        logic signed [16:0] sum;
        axis_step_t         r;
        r = '0;
        if (neg) begin
            sum = $signed({1'b0, pos}) - $signed({4'b0, delta});
        end else begin
            sum = $signed({1'b0, pos}) + $signed({4'b0, delta});
        end
        if (sum < 0) begin
            r.pos = '0;
            r.hit = 1'b1;
        end else if (sum > $signed(max_pos)) begin
            r.pos = max_pos[15:0];
            r.hit = 1'b1;
        end else begin
            r.pos = sum[15:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/cos_sin_lookup.sv
// Registered cos/sin lookup: Q8 magnitudes (256 = 1.0) plus sign flags,
// one cycle of latency, folded from a 0..90 degree quarter-wave table.
module cos_sin_lookup
    import golf_pkg::*;
(
    input  logic       clk,
    input  logic [8:0] angle,
    output logic [8:0] cos_mag,
    output logic [8:0] sin_mag,
    output logic       cos_neg,
    output logic       sin_neg
);

    logic [6:0] sin_idx;
    logic [6:0] cos_idx;
    logic       s_neg;
    logic       c_neg;

    // fold the heading into the first quadrant and derive signs
    always_comb begin
        sin_idx = '0;
        cos_idx = '0;
        s_neg   = 1'b0;
        c_neg   = 1'b0;
        if (angle <= 9'd90) begin
            sin_idx = 7'(angle);
            cos_idx = 7'(9'd90 - angle);
        end else if (angle <= 9'd180) begin
            sin_idx = 7'(9'd180 - angle);
            cos_idx = 7'(angle - 9'd90);
            c_neg   = 1'b1;
        end else if (angle <= 9'd270) begin
            sin_idx = 7'(angle - 9'd180);
            cos_idx = 7'(9'd270 - angle);
            s_neg   = 1'b1;
            c_neg   = 1'b1;
        end else begin
            sin_idx = 7'(9'd360 - angle);
            cos_idx = 7'(angle - 9'd270);
            s_neg   = 1'b1;
        end
    end

    // register table outputs
    always_ff @(posedge clk) begin
        sin_mag <= sin_q8(sin_idx);
        cos_mag <= sin_q8(cos_idx);
        sin_neg <= s_neg;
        cos_neg <= c_neg;
    end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Golf ball motion controller: aim heading with buttons, launch on a
// launch-button edge, roll with per-frame friction until the ball stops.
// Wall behaviour: define BALL_BOUNCE_EN to reflect off walls; without it a
// wall hit stops the ball.
module ball_motion_ctrl #(
    parameter int FRICTION    = 2,
    parameter int POWER_SHIFT = 2
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic        new_frame_in,
    input  logic        btn_left_in,
    input  logic        btn_right_in,
    input  logic        btn_launch_in,
    input  logic [7:0]  power_in,
    output logic [15:0] ballx_out,
    output logic [15:0] bally_out,
    output logic [15:0] angle_out,
    output logic [1:0]  state_out,
    output logic [7:0]  stroke_count_out
);
    import golf_pkg::*;

    state_t      state;
    logic [8:0]  angle;
    logic        latch_cnt;
    logic        launch_prev;
    logic [11:0] speed;
    logic [8:0]  cos_mag;
    logic [8:0]  sin_mag;
    logic        x_neg;
    logic        y_neg;
    logic        calc_pend;
    logic        upd_pend;
    logic [12:0] dx;
    logic [12:0] dy;

    logic [8:0]  lut_cos;
    logic [8:0]  lut_sin;
    logic        lut_cos_neg;
    logic        lut_sin_neg;

    logic        launch_edge;
    logic [11:0] launch_speed;
    logic [11:0] speed_dec;
    logic [11:0] speed_nxt;
    axis_step_t  step_x;
    axis_step_t  step_y;

    assign angle_out = {7'b0, angle};
    assign state_out = state;

    cos_sin_lookup u_trig (
        .clk     (pixel_clk_in),
        .angle   (angle),
        .cos_mag (lut_cos),
        .sin_mag (lut_sin),
        .cos_neg (lut_cos_neg),
        .sin_neg (lut_sin_neg)
    );

    // next-position, friction and launch arithmetic
    always_comb begin
        launch_edge  = btn_launch_in & ~launch_prev;
        launch_speed = 12'({4'b0, power_in} << POWER_SHIFT);
        step_x       = axis_step(ballx_out, dx, x_neg, X_MAX);
        step_y       = axis_step(bally_out, dy, y_neg, Y_MAX);
        speed_dec    = (int'(speed) > FRICTION) ? speed - 12'(FRICTION) : '0;
`ifdef BALL_BOUNCE_EN
        speed_nxt    = speed_dec;
`else
        speed_nxt    = (step_x.hit || step_y.hit) ? '0 : speed_dec;
`endif
    end

    // FSM with the aim, launch and two-stage roll pipeline
    always_ff @(posedge pixel_clk_in) begin
        if (!rst_in) begin
            state            <= ST_AIM;
            angle            <= '0;
            latch_cnt        <= 1'b0;
            launch_prev      <= 1'b1;
            speed            <= '0;
            cos_mag          <= '0;
            sin_mag          <= '0;
            x_neg            <= 1'b0;
            y_neg            <= 1'b0;
            calc_pend        <= 1'b0;
            upd_pend         <= 1'b0;
            dx               <= '0;
            dy               <= '0;
            ballx_out        <= START_X;
            bally_out        <= START_Y;
            stroke_count_out <= '0;
        end else begin
            launch_prev <= btn_launch_in;
            case (state)
                ST_AIM: begin
                    if (new_frame_in) begin
                        if (btn_left_in && !btn_right_in) begin
                            angle <= (angle == 9'd359) ? '0 : angle + 9'd1;
                        end else if (btn_right_in && !btn_left_in) begin
                            angle <= (angle == 9'd0) ? 9'd359 : angle - 9'd1;
                        end
                    end
                    if (launch_edge && (power_in != 8'd0)) begin
                        speed     <= launch_speed;
                        latch_cnt <= 1'b0;
                        state     <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    // second LATCH cycle: lookup output reflects the frozen angle
                    if (latch_cnt) begin
                        cos_mag   <= lut_cos;
                        sin_mag   <= lut_sin;
                        x_neg     <= ~lut_cos_neg;
                        y_neg     <= lut_sin_neg;
                        latch_cnt <= 1'b0;
                        calc_pend <= 1'b0;
                        upd_pend  <= 1'b0;
                        state     <= ST_ROLL;
                    end else begin
                        latch_cnt <= 1'b1;
                    end
                end
                ST_ROLL: begin
                    if (new_frame_in && !calc_pend && !upd_pend) begin
                        calc_pend <= 1'b1;
                    end
                    if (calc_pend) begin
                        dx        <= 13'(({9'b0, speed} * {12'b0, cos_mag}) >> 8);
                        dy        <= 13'(({9'b0, speed} * {12'b0, sin_mag}) >> 8);
                        calc_pend <= 1'b0;
                        upd_pend  <= 1'b1;
                    end
                    if (upd_pend) begin
                        upd_pend  <= 1'b0;
                        ballx_out <= step_x.pos;
                        bally_out <= step_y.pos;
                        speed     <= speed_nxt;
`ifdef BALL_BOUNCE_EN
                        if (step_x.hit) x_neg <= ~x_neg;
                        if (step_y.hit) y_neg <= ~y_neg;
`endif
                        if (speed_nxt == '0) begin
                            state <= ST_AIM;
                            if (stroke_count_out != 8'd255) begin
                                stroke_count_out <= stroke_count_out + 8'd1;
                            end
                        end
                    end
                end
                default: state <= ST_AIM;
            endcase
        end
    end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench for ball_motion_ctrl: a trig-based reference model pushes
// every expected change of the visible outputs; a monitor pops on each change.
module tb_ball_motion_ctrl;

    localparam int  FRIC = 2;
    localparam real PI   = 3.14159265358979;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        new_frame;
    logic        btn_left;
    logic        btn_right;
    logic        btn_launch;
    logic [7:0]  power;
    logic [15:0] ballx;
    logic [15:0] bally;
    logic [15:0] angle;
    logic [1:0]  state;
    logic [7:0]  stroke;

    always #5 clk = ~clk;

    ball_motion_ctrl #(.FRICTION(2), .POWER_SHIFT(2)) dut (
        .pixel_clk_in     (clk),
        .rst_in           (rst_n),
        .new_frame_in     (new_frame),
        .btn_left_in      (btn_left),
        .btn_right_in     (btn_right),
        .btn_launch_in    (btn_launch),
        .power_in         (power),
        .ballx_out        (ballx),
        .bally_out        (bally),
        .angle_out        (angle),
        .state_out        (state),
        .stroke_count_out (stroke)
    );

    typedef struct packed {
        int x;
        int y;
        int ang;
        int st;
        int stk;
    } snap_t;

    snap_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // reference model state
    int    m_x, m_y, m_ang, m_st, m_stroke, m_speed, m_cm, m_sm, m_xdir, m_ydir;
    bit    m_lprev;
    snap_t m_last;

    function automatic snap_t model_snap();
        snap_t s;
        s.x = m_x; s.y = m_y; s.ang = m_ang; s.st = m_st; s.stk = m_stroke;
        return s;
    endfunction

    function automatic void publish();
        snap_t s;
        s = model_snap();
        if (s != m_last) begin
            exp_q.push_back(s);
            m_last = s;
        end
    endfunction

    function automatic void model_reset();
        m_x = 5120; m_y = 11520; m_ang = 0; m_st = 0; m_stroke = 0; m_speed = 0;
        publish();
    endfunction

    function automatic void model_launch(int p);
        real rad, c, s;
        if (!m_lprev && m_st == 0 && p != 0) begin
            m_speed = p * 4;
            rad     = real'(m_ang) * PI / 180.0;
            c       = $cos(rad);
            s       = $sin(rad);
            m_cm    = $rtoi(((c < 0.0) ? -c : c) * 256.0 + 0.5);
            m_sm    = $rtoi(((s < 0.0) ? -s : s) * 256.0 + 0.5);
            m_xdir  = (c > 0.0) ? -1 : 1;
            m_ydir  = (s < 0.0) ? -1 : 1;
            m_st    = 1;
            publish();
            m_st    = 2;
            publish();
        end
        m_lprev = 1'b1;
    endfunction

    function automatic void model_frame(bit l, bit r);
        int nx, ny;
        bit hx, hy;
        if (m_st == 0) begin
            if (l && !r) m_ang = (m_ang + 1) % 360;
            else if (r && !l) m_ang = (m_ang + 359) % 360;
            publish();
        end else if (m_st == 2) begin
            nx = m_x + m_xdir * (m_speed * m_cm / 256);
            ny = m_y + m_ydir * (m_speed * m_sm / 256);
            hx = 0; hy = 0;
            if (nx < 0) begin nx = 0; hx = 1; end
            else if (nx > 40928) begin nx = 40928; hx = 1; end
            if (ny < 0) begin ny = 0; hy = 1; end
            else if (ny > 23008) begin ny = 23008; hy = 1; end
            m_x = nx;
            m_y = ny;
            m_speed = (m_speed > FRIC) ? m_speed - FRIC : 0;
`ifdef BALL_BOUNCE_EN
            if (hx) m_xdir = -m_xdir;
            if (hy) m_ydir = -m_ydir;
`else
            if (hx || hy) m_speed = 0;
`endif
            if (m_speed == 0) begin
                m_st = 0;
                if (m_stroke < 255) m_stroke++;
            end
            publish();
        end
    endfunction

    // monitor: every visible output change is matched against the scoreboard
    bit    mon_en = 0;
    snap_t prev_seen;

    function automatic snap_t dut_snap();
        snap_t s;
        s.x = int'(ballx); s.y = int'(bally); s.ang = int'(angle); s.st = int'(state); s.stk = int'(stroke);
        return s;
    endfunction

    always @(negedge clk) begin
        snap_t cur, e;
        if (mon_en) begin
            cur = dut_snap();
            if (cur != prev_seen) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_change: got x=%0d y=%0d ang=%0d st=%0d stk=%0d, expected no change",
                             cur.x, cur.y, cur.ang, cur.st, cur.stk);
                end else begin
                    e = exp_q.pop_front();
                    if (cur != e) begin
                        n_bad++;
                        $display("FAIL track: got x=%0d y=%0d ang=%0d st=%0d stk=%0d, expected x=%0d y=%0d ang=%0d st=%0d stk=%0d",
                                 cur.x, cur.y, cur.ang, cur.st, cur.stk, e.x, e.y, e.ang, e.st, e.stk);
                    end
                end
                prev_seen = cur;
            end
        end
    end

    task automatic chk(string name, int act, int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(bit l, bit r);
        model_frame(l, r);
        btn_left = l; btn_right = r; new_frame = 1'b1;
        cyc(1);
        new_frame = 1'b0;
        cyc(4);
    endtask

    task automatic press_launch(int p);
        model_launch(p);
        power = 8'(p); btn_launch = 1'b1;
        cyc(6);
    endtask

    task automatic release_launch();
        m_lprev = 1'b0; btn_launch = 1'b0;
        cyc(2);
    endtask

    task automatic do_reset();
        model_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        m_lprev = btn_launch;
        cyc(2);
    endtask

    task automatic set_angle(int target);
        while (m_ang != target) begin
            if (((target - m_ang + 360) % 360) <= 180) frame(1, 0);
            else frame(0, 1);
        end
    endtask

    task automatic roll_out(bit rand_btns, bit rand_launch);
        for (int k = 0; k < 700 && m_st == 2; k++) begin
            if (rand_launch && $urandom_range(0, 7) == 0) begin
                press_launch($urandom_range(1, 255));
                release_launch();
            end
            if (rand_btns) frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else frame(0, 0);
        end
        chk("roll_terminates", int'(state), m_st);
    endtask

    initial begin
        int  seen_zero;
        int  rise_ok;
        int  p;
        rst_n = 1'b0; new_frame = 0; btn_left = 0; btn_right = 0; btn_launch = 0; power = '0;
        m_x = 5120; m_y = 11520; m_ang = 0; m_st = 0; m_stroke = 0; m_speed = 0;
        m_cm = 0; m_sm = 0; m_xdir = 1; m_ydir = 1; m_lprev = 1'b1;
        m_last = model_snap();
        cyc(3);
        rst_n = 1'b1;
        m_lprev = 1'b0;
        cyc(2);

        // reset state
        chk("rst_ballx", int'(ballx), 'h1400);
        chk("rst_bally", int'(bally), 'h2D00);
        chk("rst_angle", int'(angle), 0);
        chk("rst_state", int'(state), 0);
        chk("rst_stroke", int'(stroke), 0);
        prev_seen = dut_snap();
        mon_en = 1;

        // angle buttons and wrap
        frame(0, 1); frame(0, 1);
        chk("angle_358", int'(angle), 358);
        frame(1, 0); frame(1, 0); frame(1, 0);
        chk("angle_wrap_up", int'(angle), 1);
        frame(1, 1); frame(1, 1); frame(0, 0);
        chk("angle_both_hold", int'(angle), 1);
        frame(0, 1); frame(0, 1);
        chk("angle_wrap_down", int'(angle), 359);

        // straight roll at 90 degrees, power 4
        do_reset();
        set_angle(90);
        press_launch(4);
        release_launch();
        roll_out(0, 0);
        chk("a90_bally", int'(bally), 'h2D48);
        chk("a90_ballx", int'(ballx), 'h1400);
        chk("a90_state", int'(state), 0);
        chk("a90_stroke", int'(stroke), 1);

        // zero power is ignored
        press_launch(0);
        release_launch();
        chk("zero_power_state", int'(state), 0);

        // held launch: one stroke only; a back-to-back frame pulse is dropped
        press_launch(3);
        model_frame(0, 0);
        new_frame = 1'b1;
        cyc(2);
        new_frame = 1'b0;
        cyc(4);
        roll_out(0, 0);
        frame(0, 0); frame(0, 0);
        chk("held_launch_state", int'(state), 0);
        release_launch();
        chk("held_launch_stroke", int'(stroke), 2);

        // wall at heading 0 from the start position
        do_reset();
        press_launch(255);
        release_launch();
        seen_zero = 0;
        rise_ok = 0;
        for (int k = 0; k < 700 && m_st == 2; k++) begin
            frame(0, 0);
            if (seen_zero == 1 && rise_ok == 0) rise_ok = (ballx > 16'd0) ? 1 : 2;
            if (seen_zero == 0 && ballx == 16'd0) seen_zero = 1;
        end
        chk("wall_reached_zero", seen_zero, 1);
`ifdef BALL_BOUNCE_EN
        chk("wall_bounce_rise", rise_ok, 1);
`else
        chk("wall_stop_ballx", int'(ballx), 0);
        chk("wall_stop_state", int'(state), 0);
`endif

        // randomized strokes
        for (int t = 0; t < 6; t++) begin
            set_angle($urandom_range(0, 359));
            p = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 80);
            press_launch(p);
            release_launch();
            roll_out(1, 1);
            chk("rand_stroke", int'(stroke), m_stroke);
            chk("rand_angle", int'(angle), m_ang);
        end

        // reset during the third ROLL frame
        do_reset();
        set_angle(45);
        press_launch(20);
        release_launch();
        frame(0, 0); frame(0, 0);
        model_reset();
        new_frame = 1'b1;
        cyc(1);
        new_frame = 1'b0;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        m_lprev = btn_launch;
        chk("midroll_ballx", int'(ballx), 'h1400);
        chk("midroll_bally", int'(bally), 'h2D00);
        chk("midroll_state", int'(state), 0);
        chk("midroll_stroke", int'(stroke), 0);
        cyc(6);
        chk("midroll_settled_state", int'(state), 0);

        cyc(5);
        chk("queue_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ball_motion_ctrl.md
BALL_MOTION_CTRL -- requirements
Module: ball_motion_ctrl

Interface
REQ-001 SHALL have parameter FRICTION, default 2: speed decrement per frame, in 1/32-pixel units.
REQ-002 SHALL have parameter POWER_SHIFT, default 2: launch speed is power_in shifted left by this amount.
REQ-003 SHALL have port pixel_clk_in, input, 1 bit: the single clock.
REQ-004 SHALL have port rst_in, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port new_frame_in, input, 1 bit: single-cycle pulse, once per video frame.
REQ-006 SHALL have ports btn_left_in, btn_right_in and btn_launch_in, input, 1 bit each: debounced button levels.
REQ-007 SHALL have port power_in, input, 8 bits: launch power.
REQ-008 SHALL have ports ballx_out and bally_out, output, 16 bits each: ball map position, unsigned 11.5 fixed point.
REQ-009 SHALL have port angle_out, output, 16 bits: view/aim heading in degrees, 0..359.
REQ-010 SHALL have port state_out, output, 2 bits: FSM state (AIM=0, LATCH=1, ROLL=2).
REQ-011 SHALL have port stroke_count_out, output, 8 bits: completed strokes.

Function
REQ-012 SHALL implement FSM AIM -> LATCH -> ROLL -> AIM.
REQ-013 In AIM, on new_frame_in, SHALL change angle_out as follows:
- btn_left_in only: +1, wrapping 359 -> 0.
- btn_right_in only: -1, wrapping 0 -> 359.
- both or neither: no change.
REQ-014 In AIM, a rising edge of btn_launch_in with power_in != 0 SHALL latch speed = power_in << POWER_SHIFT (12-bit) and enter LATCH.
REQ-015 A launch edge with power_in == 0, or any launch edge outside AIM, SHALL be ignored; a held launch level SHALL NOT retrigger.
REQ-016 LATCH SHALL last exactly 2 cycles, absorbing trig lookup latency.
REQ-017 On leaving LATCH, SHALL register cos/sin magnitudes (Q8, 256 = 1.0) and the x/y direction flags, then enter ROLL.
REQ-018 Direction convention: x moves by -cos(angle), y moves by +sin(angle), using the lookup sign bits.
REQ-019 In ROLL, on new_frame_in at cycle N:
- cycle N+1: register dx = (speed*cos_mag)>>8 and dy = (speed*sin_mag)>>8, 13 bits each.
- cycle N+2: update ballx_out/bally_out and set speed = max(speed - FRICTION, 0).
REQ-020 A new_frame_in pulse arriving while an update is pending SHALL be dropped.
REQ-021 Position arithmetic SHALL use 17-bit signed intermediates, with bounds X_MAX = 40928 (1279 px) and Y_MAX = 23008 (719 px).
REQ-022 When an axis under/overflows, that axis SHALL clamp to 0 or its MAX (wall behaviour per REQ-029).
REQ-023 When speed reaches 0 at N+2, SHALL go to AIM and increment stroke_count_out, saturating at 255.
REQ-024 angle_out SHALL be constant outside AIM; ballx_out/bally_out SHALL change only at N+2 of a ROLL update.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 When rst_in is low at a clock edge, SHALL on that edge set:
- ballx_out = 0x1400 (160 px), bally_out = 0x2D00 (360 px)
- angle_out = 0, state AIM, stroke_count_out = 0
- speed = 0, direction flags cleared, pending update cleared.
REQ-027 Reset mid-ROLL or mid-LATCH SHALL abandon the stroke with no stroke count increment.
REQ-028 The launch edge detector SHALL initialise to 1, so a button held through reset does not launch.

Configuration
REQ-029 The wall behaviour SHALL be selected by macro BALL_BOUNCE_EN:
- defined: on clamp, invert that axis's direction flag and continue rolling.
- undefined: on clamp, force speed = 0, so the ball stops and the FSM returns to AIM per REQ-023.

Structure
REQ-030 Package golf_pkg SHALL hold the FSM state enum and the constants START_X, START_Y, X_MAX, Y_MAX.
REQ-031 SHALL instantiate exactly one cos_sin_lookup (1-cycle latency, Q8 magnitude plus sign outputs), driven by angle_out.

Verification
REQ-032 Reset -> ballx 0x1400, bally 0x2D00, angle 0, state_out 0, stroke 0.
REQ-033 Angle buttons:
- angle 358, btn_left held 3 frames -> 359, 0, 1.
- angle 0, btn_right 1 frame -> 359.
- both held -> unchanged.
REQ-034 Angle 90, power 4 -> speed 16; bally steps +16, +14, ... +2; final bally = 0x2D48; back to AIM; stroke 1; ballx unchanged.
REQ-035 Launch rejection: power 0 -> stays AIM; launch held across 2 frames -> only one stroke.
REQ-036 Wall: angle 0, power 255, from start -> ballx reaches 0.
- with BALL_BOUNCE_EN: next update ballx increases.
- without: state returns to AIM with ballx 0.
REQ-037 rst_in low during ROLL frame 3 -> reset values on the next edge, stroke 0.
